regfile_write_ctrl: RTL and testbench
=====================================

# regfile_write_ctrl

Write-port controller for the register file. It owns the register file's single write port (write_enable, dest_addr and write_data). After every reset it clears all registers to zero in a sequence. It then shares the port between two writeback requesters (A = ALU, B = load/memory) using round-robin arbitration with valid/ready handshakes. Its outputs are registered on the rising clock edge, so they are stable when the register file commits on the falling edge.

## Interface
- BIT_NUMBER, 64, data width.
- ADDR_NUMBER, 5, address width.
- REGISTER_NUMBER, 16, number of physical registers (≤ 2^ADDR_NUMBER).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A's write is accepted on this edge if a_valid.
- a_addr  in  ADDR_NUMBER  A's destination register.
- a_data  in  BIT_NUMBER  A's write data.
- b_valid, b_ready, b_addr, b_data: same meaning for requester B.
- wr_en  out  1  connects to the register file's write_enable.
- wr_addr  out  ADDR_NUMBER  connects to dest_addr.
- wr_data  out  BIT_NUMBER  connects to write_data.
- init_busy  out  1  high while the clear sequence runs.
- addr_err  out  1  sticky; set when an accepted request has an address ≥ REGISTER_NUMBER.

## Operation
- **States:**
  - INIT (clearing): entered on reset.
  - RUN: arbitration and normal writes.
  - Also held: clear counter cnt (ADDR_NUMBER bits) and round-robin pointer prio (0 = A favoured, 1 = B favoured).
- **Reset (edge with reset high):**
  - state = INIT, cnt = 0, prio = 0.
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - init_busy = 1, addr_err = 0.
  - a_ready = b_ready = 0.
  - A reset asserted mid-clear or mid-RUN has the same effect and restarts the clear from register 0. Requests presented during that edge are not accepted.
- **INIT:**
  - Each edge loads wr_en = 1, wr_addr = cnt, wr_data = 0, then increments cnt.
  - On the edge that loads wr_addr = REGISTER_NUMBER-1, the state moves to RUN and init_busy goes to 0.
  - a_ready = b_ready = 0 throughout; requesters hold their valid, addr and data.
- **RUN (ready logic is combinational from state, valids and prio):**
  - a_ready = RUN & (!b_valid | prio==0).
  - b_ready = RUN & (!a_valid | prio==1).
  - At most one acceptance per edge.
- **Acceptance (valid & ready on an edge):**
  - Loads wr_addr = addr and wr_data = data.
  - Loads wr_en = 1 if addr < REGISTER_NUMBER. Otherwise wr_en = 0 and addr_err is set to 1; it stays set until reset.
  - prio is set to the other requester.
- **No acceptance in RUN:** wr_en = 0; wr_addr and wr_data hold their last values; prio holds.
- **Conflicts:** the controller does no write coalescing. If A and B target the same register, both writes happen, in grant order.

## Timing
- **Clear duration:** exactly REGISTER_NUMBER cycles of wr_en = 1 (addresses 0..REGISTER_NUMBER-1, ascending, no gaps).
- **First possible acceptance:** the first edge after init_busy falls, i.e. REGISTER_NUMBER+1 edges after reset deasserts.
- **Write latency:**
  - Acceptance at edge N drives wr_en/wr_addr/wr_data during cycle N to N+1.
  - The register file commits at that cycle's falling edge.
  - Register reads return the new value from that falling edge on.
- **Throughput:** one write per cycle. With both requesters continuously valid, grants alternate A, B, A, B…, starting with whichever prio favours.
- **Single requester:** granted every cycle; after each grant prio points to the idle requester.
- **Ready dependence:** a_ready/b_ready may depend combinationally on the other requester's valid. Requesters must not make valid depend on ready.

## Test plan
- **Reset clear:** deassert reset with REGISTER_NUMBER=16 → wr_en = 1 for 16 consecutive cycles, wr_addr = 0..15, wr_data = 0. init_busy falls with the wr_addr = 15 cycle; a_ready = b_ready = 0 throughout.
- **Round-robin:** after init, hold a_valid = b_valid = 1 for 4 cycles with A = (3, 0x11), B = (5, 0x22) → writes in order A, B, A, B (wr_addr 3, 5, 3, 5); each requester is ready on alternate cycles.
- **Single requester and fairness:**
  - Only a_valid for 3 cycles with addr 7 → three consecutive writes to register 7.
  - Then assert both valids → B is granted first.
- **Out-of-range address:** A writes addr 20 with data 0xFF → handshake completes, wr_en stays 0, addr_err = 1. A following valid write to addr 2 is performed and addr_err remains 1.
- **Reset mid-operation:** assert reset during a clear at cnt = 9 and again during RUN traffic → outputs take their reset values on that edge; the clear restarts at address 0 and no request is accepted until it completes.
- **Read-after-write:** accept A = (4, 0xDEAD_BEEF) at edge N → the register file's data_out for src_addr 4 shows 0xDEAD_BEEF after the falling edge of cycle N.

Source files
------------

// File: rtl/regfile_write_ctrl_if.sv
// Write-port bus between the two writeback requesters, the write controller and the
// register file.
interface regfile_write_ctrl_if #(
    parameter int unsigned BIT_NUMBER  = 64,
    parameter int unsigned ADDR_NUMBER = 5
);
    logic                   a_valid;
    logic                   a_ready;
    logic [ADDR_NUMBER-1:0] a_addr;
    logic [BIT_NUMBER-1:0]  a_data;
    logic                   b_valid;
    logic                   b_ready;
    logic [ADDR_NUMBER-1:0] b_addr;
    logic [BIT_NUMBER-1:0]  b_data;
    logic                   wr_en;
    logic [ADDR_NUMBER-1:0] wr_addr;
    logic [BIT_NUMBER-1:0]  wr_data;
    logic                   init_busy;
    logic                   addr_err;

    // Requester / register-file side.
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, wr_en, wr_addr, wr_data, init_busy, addr_err
    );

    // Write controller side.
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, wr_en, wr_addr, wr_data, init_busy, addr_err
    );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port controller: clears every register after reset, then
// round-robin arbitrates two writeback requesters onto the single write port.
module regfile_write_ctrl #(
    parameter int unsigned BIT_NUMBER      = 64,
    parameter int unsigned ADDR_NUMBER     = 5,
    parameter int unsigned REGISTER_NUMBER = 16
) (
    input logic                clk,
    input logic                reset,
    regfile_write_ctrl_if.slave bus
);
    localparam logic [ADDR_NUMBER:0]   RegNum   = (ADDR_NUMBER + 1)'(REGISTER_NUMBER);
    localparam logic [ADDR_NUMBER-1:0] LastAddr = ADDR_NUMBER'(REGISTER_NUMBER - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                 state;
    logic [ADDR_NUMBER-1:0] cnt;
    logic                   prio;
    logic                   wr_en_q;
    logic [ADDR_NUMBER-1:0] wr_addr_q;
    logic [BIT_NUMBER-1:0]  wr_data_q;
    logic                   init_busy_q;
    logic                   addr_err_q;

    logic                   a_ready;
    logic                   b_ready;
    logic                   a_grant;
    logic                   b_grant;
    logic                   in_range;
    logic [ADDR_NUMBER-1:0] sel_addr;
    logic [BIT_NUMBER-1:0]  sel_data;

    // Ready is masked during a reset cycle so no handshake completes on the reset edge.
    always_comb begin
        a_ready  = (state == StRun) & ~reset & (~bus.b_valid | ~prio);
        b_ready  = (state == StRun) & ~reset & (~bus.a_valid | prio);
        a_grant  = bus.a_valid & a_ready;
        b_grant  = bus.b_valid & b_ready;
        sel_addr = b_grant ? bus.b_addr : bus.a_addr;
        sel_data = b_grant ? bus.b_data : bus.a_data;
        in_range = {1'b0, sel_addr} < RegNum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StInit;
            cnt         <= '0;
            prio        <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            init_busy_q <= 1'b1;
            addr_err_q  <= 1'b0;
        end else begin
            case (state)
                StInit: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cnt;
                    wr_data_q <= '0;
                    cnt       <= cnt + ADDR_NUMBER'(1);
                    if (cnt == LastAddr) begin
                        state       <= StRun;
                        init_busy_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (a_grant || b_grant) begin
                        wr_addr_q <= sel_addr;
                        wr_data_q <= sel_data;
                        wr_en_q   <= in_range;
                        if (!in_range) begin
                            addr_err_q <= 1'b1;
                        end
                        // Favour whichever requester was not just served.
                        prio <= a_grant;
                    end else begin
                        wr_en_q <= 1'b0;
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

    assign bus.a_ready   = a_ready;
    assign bus.b_ready   = b_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.init_busy = init_busy_q;
    assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Bench for regfile_write_ctrl: directed requester traffic with a write scoreboard and a
// small register-file model committing on the falling edge.
module tb_regfile_write_ctrl;
    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    wr_t  exp_q[$];
    logic [63:0] rf [0:31];

    regfile_write_ctrl_if #(.BIT_NUMBER(64), .ADDR_NUMBER(5)) bus ();

    regfile_write_ctrl #(
        .BIT_NUMBER(64),
        .ADDR_NUMBER(5),
        .REGISTER_NUMBER(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Register file model: commits on the falling edge.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) rf[bus.wr_addr] <= bus.wr_data;
    end

    // Monitor: every write seen on the port must match the next scoreboard entry.
    always @(negedge clk) begin
        wr_t e;
        if (bus.wr_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got en=%b addr=%0d data=%0h, want no write",
                         bus.wr_en, bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                check("wr_data", bus.wr_data, e.data);
            end
        end
    end

    // Drive one cycle of requests, check readies, log expected write, cross one edge.
    task automatic step(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [63:0] bd,
                        input logic chk, input logic ear, input logic ebr);
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_addr  = ba;
        bus.b_data  = bd;
        #1;
        if (chk) begin
            check("a_ready", 64'(bus.a_ready), 64'(ear));
            check("b_ready", 64'(bus.b_ready), 64'(ebr));
            if (av && ear && aa < 5'd16) exp_q.push_back('{addr: aa, data: ad});
            if (bv && ebr && ba < 5'd16) exp_q.push_back('{addr: ba, data: bd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v);
        reset = 1'b1;
        step(v, 5'd3, 64'h11, v, 5'd5, 64'h22, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("rst_wr_data", bus.wr_data, 64'd0);
        check("rst_init_busy", 64'(bus.init_busy), 64'd1);
        check("rst_addr_err", 64'(bus.addr_err), 64'd0);
    endtask

    task automatic do_clear(input int n, input logic v);
        for (int i = 0; i < n; i++) exp_q.push_back('{addr: 5'(i), data: 64'h0});
        for (int i = 0; i < n; i++) begin
            step(v, 5'd3, 64'h11, v, 5'd5, 64'h22, 1'b1, 1'b0, 1'b0);
            check("init_busy", 64'(bus.init_busy), (i < 15) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Full clear with both requesters already waiting.
        do_clear(16, 1'b1);

        // Round-robin with both valid: A, B, A, B.
        step(1, 5'd3, 64'h11, 1, 5'd5, 64'h22, 1, 1, 0);
        step(1, 5'd3, 64'h11, 1, 5'd5, 64'h22, 1, 0, 1);
        step(1, 5'd3, 64'h11, 1, 5'd5, 64'h22, 1, 1, 0);
        step(1, 5'd3, 64'h11, 1, 5'd5, 64'h22, 1, 0, 1);

        // Single requester A three times, then both: B first, then A.
        step(1, 5'd7, 64'h70, 0, 5'd0, 64'h0, 1, 1, 0);
        step(1, 5'd7, 64'h71, 0, 5'd0, 64'h0, 1, 1, 1);
        step(1, 5'd7, 64'h72, 0, 5'd0, 64'h0, 1, 1, 1);
        step(1, 5'd7, 64'h73, 1, 5'd9, 64'h99, 1, 0, 1);
        step(1, 5'd7, 64'h73, 1, 5'd9, 64'h99, 1, 1, 0);

        // Out-of-range address: accepted, no write, sticky error.
        step(1, 5'd20, 64'hFF, 0, 5'd0, 64'h0, 1, 1, 1);
        check("oor_wr_en", 64'(bus.wr_en), 64'd0);
        check("oor_addr_err", 64'(bus.addr_err), 64'd1);
        step(1, 5'd2, 64'h202, 0, 5'd0, 64'h0, 1, 1, 1);
        check("err_sticky", 64'(bus.addr_err), 64'd1);

        // Read-after-write through the falling-edge register file.
        step(1, 5'd4, 64'hDEAD_BEEF, 0, 5'd0, 64'h0, 1, 1, 1);
        bus.a_valid = 1'b0;
        check("raw_before", rf[4], 64'h0);
        @(negedge clk);
        #1;
        check("raw_after", rf[4], 64'hDEAD_BEEF);
        @(posedge clk);
        #1;

        // Reset mid-clear at cnt = 9; clear restarts from 0 and clears addr_err.
        do_reset(1'b0);
        do_clear(9, 1'b0);
        do_reset(1'b1);
        do_clear(16, 1'b1);
        step(1, 5'd3, 64'h11, 1, 5'd5, 64'h22, 1, 1, 0);

        // Reset during RUN traffic.
        do_reset(1'b1);
        do_clear(16, 1'b1);
        step(1, 5'd3, 64'h11, 1, 5'd5, 64'h22, 1, 1, 0);

        for (int i = 0; i < 3; i++) step(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 1, 1, 1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
